file_stream_pager: RTL and testbench
====================================

FILE_STREAM_PAGER -- requirements
Module: file_stream_pager

Interface
REQ-001 Parameters SHALL be: DW, 8, byte width; FIFO_AW, 10, FIFO depth = 2**FIFO_AW; PAGE_LEN, 64, bytes per page (1..65535); MODE, "PAGED", "PAGED" or "STREAM"; DEBOUNCE_CYC, 1000000, stable cycles required on next.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 sole clock; rst in 1 reset.
REQ-003 Reset SHALL be synchronous and active-high, with the single clock clk.
REQ-004 i_en in 1 input byte strobe, no backpressure; i_data in DW input byte; i_eof in 1 end-of-file pulse.
REQ-005 next in 1 raw asynchronous push-button, active-high.
REQ-006 o_tvalid out 1; o_tready in 1; o_tdata out DW; o_tlast out 1, last byte of page or file.
REQ-007 page_cnt out 16 pages started; ovf_cnt out 16 dropped bytes; fifo_level out FIFO_AW+1 occupancy; state out 2 current FSM state.

Function
REQ-008 The FIFO SHALL be show-ahead: o_tdata equals the head entry whenever o_tvalid=1.
REQ-009 Push SHALL occur when i_en=1 and (not full or pop in same cycle) and eof_seen=0.
REQ-010 Pop SHALL occur when o_tvalid=1 and o_tready=1.
REQ-011 A push on a full FIFO without a simultaneous pop SHALL drop the byte and increment ovf_cnt, saturating at 16'hFFFF.
REQ-012 On i_eof=1, eof_seen SHALL set at the next edge; an i_en byte in the same cycle SHALL still be pushed; later i_en SHALL be ignored until rst.
REQ-013 Push-to-visibility latency SHALL be 1 cycle: a byte written into an empty FIFO at edge N SHALL show o_tvalid=1 after edge N in SEND.
REQ-014 next SHALL pass a 2-FF synchroniser, then a debouncer updating its level only after DEBOUNCE_CYC consecutive equal samples.
REQ-015 A press SHALL be a 0->1 edge of the debounced level, one cycle wide.
REQ-016 FSM states SHALL be WAIT_NEXT=0, SEND=1, DONE=2, driven on the state output.
REQ-017 WAIT_NEXT -> SEND SHALL occur on a press in PAGED mode, or unconditionally next cycle in STREAM mode; page_cnt SHALL increment (wrapping) and byte_cnt SHALL clear on entry.
REQ-018 WAIT_NEXT -> DONE SHALL occur when eof_seen=1 and the FIFO is empty, with priority over a press.
REQ-019 In SEND, o_tvalid SHALL equal FIFO non-empty; an empty FIFO stalls the page without ending it.
REQ-020 o_tlast SHALL be 1 when byte_cnt=PAGE_LEN-1, or when eof_seen=1 and fifo_level=1.
REQ-021 A pop with o_tlast=1 SHALL move SEND -> WAIT_NEXT, or SEND -> DONE if eof_seen=1 and the FIFO becomes empty.
REQ-022 Presses in SEND or DONE SHALL be ignored and not queued.
REQ-023 DONE SHALL hold o_tvalid=0 until rst.
REQ-024 o_tvalid, o_tdata and o_tlast SHALL stay stable while o_tvalid=1 and o_tready=0.
REQ-025 fifo_level SHALL stay unchanged on a simultaneous push and pop.

Reset
REQ-026 rst SHALL override all other inputs in the cycle it is sampled high.
REQ-027 On rst: state=WAIT_NEXT, o_tvalid=0, o_tlast=0, o_tdata=0, FIFO empty, page_cnt=0, ovf_cnt=0, byte_cnt=0, eof_seen=0, debounced level=0, debounce counter=0.
REQ-028 A rst mid-page SHALL discard FIFO contents; no partial page SHALL resume afterwards.

Structure
REQ-029 FSM state encodings and MODE string constants SHALL reside in shared package file_pager_pkg.
REQ-030 The FIFO SHALL be a separate sub-module sync_fifo (parameters DW, AW; show-ahead; full, empty and level outputs).
REQ-031 Debouncer and FSM SHALL be inline in file_stream_pager.

Verification
REQ-032 PAGED, PAGE_LEN=4, o_tready=1: push 10 bytes 0x41..0x4A, then press -> 0x41..0x44 with o_tlast on 0x44, page_cnt=1, state=WAIT_NEXT.
REQ-033 Continue: i_eof, then two presses -> 0x45..0x48 (tlast on 0x48), then 0x49..0x4A (tlast on 0x4A); state=DONE, fifo_level=0.
REQ-034 FIFO_AW=2: push 6 bytes without popping -> fifo_level=4, ovf_cnt=2; first four bytes delivered in order.
REQ-035 Backpressure: o_tready toggled 1,0,0,1 during a page -> o_tdata held across stall cycles, no byte lost or duplicated.
REQ-036 DEBOUNCE_CYC=8: next glitch of 5 cycles -> no press; next held 20 cycles -> exactly one press; press during SEND -> ignored.
REQ-037 STREAM, PAGE_LEN=3: push 7 bytes, then i_eof -> continuous output with o_tlast on bytes 3, 6 and 7, page_cnt=3, state=DONE; rst mid-stream -> o_tvalid=0 next cycle, fifo_level=0.

Source files
------------

// File: rtl/file_pager_pkg.sv
// Shared definitions for the file stream pager: FSM encodings, MODE names and
// a saturating counter helper.
package file_pager_pkg;

    typedef enum logic [1:0] {
        WAIT_NEXT = 2'd0,
        SEND      = 2'd1,
        DONE      = 2'd2
    } pager_state_e;

    localparam string MODE_PAGED  = "PAGED";
    localparam string MODE_STREAM = "STREAM";

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return value + 16'd1;
        end
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO: rdata_o always presents the head entry.
// push_i/pop_i arrive pre-qualified by the caller.
module sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [DW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   LVL_ONE = (AW + 1)'(1);

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = push_i ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = pop_i  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        case ({push_i, pop_i})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = level_q[AW];
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/file_stream_pager.sv
// Buffers an incoming file byte stream and releases it page by page on a
// debounced push-button (PAGED) or continuously (STREAM) over a valid/ready port.
module file_stream_pager
    import file_pager_pkg::*;
#(
    parameter int    DW           = 8,
    parameter int    FIFO_AW      = 10,
    parameter int    PAGE_LEN     = 64,
    parameter string MODE         = "PAGED",
    parameter int    DEBOUNCE_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [DW-1:0]      i_data,
    input  logic               i_eof,
    input  logic               next,
    output logic               o_tvalid,
    input  logic               o_tready,
    output logic [DW-1:0]      o_tdata,
    output logic               o_tlast,
    output logic [15:0]        page_cnt,
    output logic [15:0]        ovf_cnt,
    output logic [FIFO_AW:0]   fifo_level,
    output logic [1:0]         state
);

    localparam bit              IS_STREAM = (MODE == MODE_STREAM);
    localparam int              DBW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [DBW-1:0]  DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
    localparam logic [DBW-1:0]  DB_ONE    = DBW'(1);
    localparam logic [15:0]     LAST_IDX  = 16'(PAGE_LEN - 1);
    localparam logic [FIFO_AW:0] LVL_ONE  = (FIFO_AW + 1)'(1);

    pager_state_e state_q, state_d;
    logic [15:0]  page_cnt_q, page_cnt_d;
    logic [15:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0]  ovf_cnt_q, ovf_cnt_d;
    logic         eof_seen_q, eof_seen_d;
    logic [1:0]   sync_q, sync_d;
    logic         db_level_q, db_level_d;
    logic         db_prev_q, db_prev_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;

    logic          fifo_full_s, fifo_empty_s;
    logic [DW-1:0] fifo_head_s;
    logic [FIFO_AW:0] fifo_level_s;
    logic          push_s, pop_s, ovf_s, press_s, tvalid_s, tlast_s;

    sync_fifo #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_s),
        .wdata_i (i_data),
        .pop_i   (pop_s),
        .rdata_o (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (fifo_level_s)
    );

    assign tvalid_s = (state_q == SEND) && !fifo_empty_s;
    assign tlast_s  = tvalid_s && ((byte_cnt_q == LAST_IDX) ||
                                   (eof_seen_q && (fifo_level_s == LVL_ONE)));
    assign pop_s    = tvalid_s && o_tready;
    assign push_s   = i_en && !eof_seen_q && (!fifo_full_s || pop_s);
    assign ovf_s    = i_en && !eof_seen_q && fifo_full_s && !pop_s;
    assign press_s  = db_level_q && !db_prev_q;

    // Button synchroniser and debouncer: level follows only after a full run of differing samples
    always_comb begin
        sync_d     = {sync_q[0], next};
        db_prev_d  = db_level_q;
        db_level_d = db_level_q;
        db_cnt_d   = '0;
        if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
                db_level_d = sync_q[1];
                db_cnt_d   = '0;
            end else begin
                db_cnt_d   = db_cnt_q + DB_ONE;
            end
        end else begin
            db_cnt_d = '0;
        end
    end

    // Page FSM and counters
    always_comb begin
        state_d    = state_q;
        page_cnt_d = page_cnt_q;
        byte_cnt_d = byte_cnt_q;
        eof_seen_d = eof_seen_q || i_eof;
        ovf_cnt_d  = ovf_s ? sat_inc16(ovf_cnt_q) : ovf_cnt_q;
        case (state_q)
            WAIT_NEXT: begin
                if (eof_seen_q && fifo_empty_s) begin
                    state_d = DONE;
                end else if (IS_STREAM || press_s) begin
                    state_d    = SEND;
                    page_cnt_d = page_cnt_q + 16'd1;
                    byte_cnt_d = 16'd0;
                end else begin
                    state_d = WAIT_NEXT;
                end
            end
            SEND: begin
                if (pop_s) begin
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    if (tlast_s) begin
                        state_d = (eof_seen_q && (fifo_level_s == LVL_ONE)) ? DONE : WAIT_NEXT;
                    end else begin
                        state_d = SEND;
                    end
                end else if (eof_seen_q && fifo_empty_s) begin
                    // Nothing more can ever arrive, so a stalled page would never end
                    state_d = DONE;
                end else begin
                    state_d = SEND;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = WAIT_NEXT;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_NEXT;
            page_cnt_q <= 16'd0;
            byte_cnt_q <= 16'd0;
            ovf_cnt_q  <= 16'd0;
            eof_seen_q <= 1'b0;
            sync_q     <= 2'b00;
            db_level_q <= 1'b0;
            db_prev_q  <= 1'b0;
            db_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            page_cnt_q <= page_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
            eof_seen_q <= eof_seen_d;
            sync_q     <= sync_d;
            db_level_q <= db_level_d;
            db_prev_q  <= db_prev_d;
            db_cnt_q   <= db_cnt_d;
        end
    end

    assign o_tvalid   = tvalid_s;
    assign o_tdata    = tvalid_s ? fifo_head_s : '0;
    assign o_tlast    = tlast_s;
    assign page_cnt   = page_cnt_q;
    assign ovf_cnt    = ovf_cnt_q;
    assign fifo_level = fifo_level_s;
    assign state      = state_q;

endmodule

// File: tb/tb_file_stream_pager.sv
// Directed bench for file_stream_pager: three instances (paged, tiny FIFO, stream)
// share stimulus; only the one out of reset is active and observed.
module tb_file_stream_pager;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b, rst_c;
    logic       i_en, i_eof, next, o_tready;
    logic [7:0] i_data;

    logic tv_a, tl_a, tv_b, tl_b, tv_c, tl_c;
    logic [7:0]  td_a, td_b, td_c;
    logic [15:0] pc_a, oc_a, pc_b, oc_b, pc_c, oc_c;
    logic [4:0]  lv_a, lv_c;
    logic [2:0]  lv_b;
    logic [1:0]  st_a, st_b, st_c;

    file_stream_pager #(.DW(8), .FIFO_AW(4), .PAGE_LEN(4), .MODE("PAGED"), .DEBOUNCE_CYC(8)) u_a (
        .clk(clk), .rst(rst_a), .i_en(i_en), .i_data(i_data), .i_eof(i_eof), .next(next),
        .o_tvalid(tv_a), .o_tready(o_tready), .o_tdata(td_a), .o_tlast(tl_a),
        .page_cnt(pc_a), .ovf_cnt(oc_a), .fifo_level(lv_a), .state(st_a));

    file_stream_pager #(.DW(8), .FIFO_AW(2), .PAGE_LEN(4), .MODE("PAGED"), .DEBOUNCE_CYC(4)) u_b (
        .clk(clk), .rst(rst_b), .i_en(i_en), .i_data(i_data), .i_eof(i_eof), .next(next),
        .o_tvalid(tv_b), .o_tready(o_tready), .o_tdata(td_b), .o_tlast(tl_b),
        .page_cnt(pc_b), .ovf_cnt(oc_b), .fifo_level(lv_b), .state(st_b));

    file_stream_pager #(.DW(8), .FIFO_AW(4), .PAGE_LEN(3), .MODE("STREAM"), .DEBOUNCE_CYC(8)) u_c (
        .clk(clk), .rst(rst_c), .i_en(i_en), .i_data(i_data), .i_eof(i_eof), .next(next),
        .o_tvalid(tv_c), .o_tready(o_tready), .o_tdata(td_c), .o_tlast(tl_c),
        .page_cnt(pc_c), .ovf_cnt(oc_c), .fifo_level(lv_c), .state(st_c));

    int checks = 0;
    int errors = 0;
    int sel = 0;

    logic       m_tvalid, m_tlast;
    logic [7:0] m_tdata;
    logic [7:0] q_data[$];
    logic       q_last[$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic       stall_last = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always_comb begin
        case (sel)
            0:       begin m_tvalid = tv_a; m_tdata = td_a; m_tlast = tl_a; end
            1:       begin m_tvalid = tv_b; m_tdata = td_b; m_tlast = tl_b; end
            default: begin m_tvalid = tv_c; m_tdata = td_c; m_tlast = tl_c; end
        endcase
    end

    // Output monitor: records accepted beats and checks hold-steady during stalls
    always @(negedge clk) begin
        if (stall_q) begin
            check("hold_valid", {31'd0, m_tvalid}, 32'd1);
            check("hold_data", {24'd0, m_tdata}, {24'd0, stall_data});
            check("hold_last", {31'd0, m_tlast}, {31'd0, stall_last});
        end
        if (m_tvalid && o_tready) begin
            q_data.push_back(m_tdata);
            q_last.push_back(m_tlast);
        end
        stall_q    <= m_tvalid && !o_tready;
        stall_data <= m_tdata;
        stall_last <= m_tlast;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            i_en   = 1'b1;
            i_data = first + 8'(i);
            tick(1);
        end
        i_en = 1'b0;
    endtask

    task automatic press();
        next = 1'b1;
        tick(20);
        next = 1'b0;
        tick(20);
    endtask

    task automatic wait_bytes(input int n, input string tag);
        for (int k = 0; k < 300; k++) begin
            if (q_data.size() >= n) break;
            tick(1);
        end
        check(tag, q_data.size(), n);
    endtask

    task automatic check_bytes(input logic [7:0] first, input int n, input logic [15:0] last_mask);
        for (int i = 0; i < n; i++) begin
            if (i < q_data.size()) begin
                check("data", {24'd0, q_data[i]}, {24'd0, first + 8'(i)});
                check("tlast", {31'd0, q_last[i]}, {31'd0, last_mask[i]});
            end
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
    endtask

    logic [3:0] rdy_pat = 4'b1001;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        i_en = 1'b0; i_eof = 1'b0; next = 1'b0; o_tready = 1'b1; i_data = 8'h00;
        tick(3);

        // Reset state of the paged instance
        check("rst_state", {30'd0, st_a}, 32'd0);
        check("rst_tvalid", {31'd0, tv_a}, 32'd0);
        check("rst_tlast", {31'd0, tl_a}, 32'd0);
        check("rst_tdata", {24'd0, td_a}, 32'd0);
        check("rst_level", {27'd0, lv_a}, 32'd0);
        check("rst_page", {16'd0, pc_a}, 32'd0);
        check("rst_ovf", {16'd0, oc_a}, 32'd0);

        // Debounce: glitch rejected, held press counts once, press in SEND ignored
        sel = 0; rst_a = 1'b0; tick(2);
        next = 1'b1; tick(5); next = 1'b0; tick(20);
        check("glitch_state", {30'd0, st_a}, 32'd0);
        check("glitch_page", {16'd0, pc_a}, 32'd0);
        press();
        check("press_page", {16'd0, pc_a}, 32'd1);
        check("press_state", {30'd0, st_a}, 32'd1);
        press();
        check("send_press_page", {16'd0, pc_a}, 32'd1);
        check("send_press_state", {30'd0, st_a}, 32'd1);
        clear_q();
        push_bytes(8'h10, 4);
        wait_bytes(4, "deb_count");
        check_bytes(8'h10, 4, 16'b1000);
        tick(30);
        check("no_queued_state", {30'd0, st_a}, 32'd0);
        check("no_queued_page", {16'd0, pc_a}, 32'd1);

        // Paged delivery of 10 bytes across three pages with eof
        rst_a = 1'b1; tick(1); rst_a = 1'b0;
        push_bytes(8'h41, 10);
        check("pre_level", {27'd0, lv_a}, 32'd10);
        check("pre_tvalid", {31'd0, tv_a}, 32'd0);
        clear_q();
        press();
        wait_bytes(4, "p1_count");
        check_bytes(8'h41, 4, 16'b1000);
        check("p1_page", {16'd0, pc_a}, 32'd1);
        check("p1_state", {30'd0, st_a}, 32'd0);
        check("p1_level", {27'd0, lv_a}, 32'd6);
        i_eof = 1'b1; tick(1); i_eof = 1'b0;
        push_bytes(8'hEE, 2);
        check("eof_ignore_level", {27'd0, lv_a}, 32'd6);
        clear_q();
        press();
        wait_bytes(4, "p2_count");
        check_bytes(8'h45, 4, 16'b1000);
        check("p2_state", {30'd0, st_a}, 32'd0);
        clear_q();
        press();
        wait_bytes(2, "p3_count");
        check_bytes(8'h49, 2, 16'b10);
        check("done_state", {30'd0, st_a}, 32'd2);
        check("done_level", {27'd0, lv_a}, 32'd0);
        check("done_tvalid", {31'd0, tv_a}, 32'd0);
        check("done_page", {16'd0, pc_a}, 32'd3);

        // Backpressure pattern 1,0,0,1 during a page
        rst_a = 1'b1; tick(1); rst_a = 1'b0;
        push_bytes(8'h21, 4);
        o_tready = 1'b0;
        press();
        clear_q();
        for (int i = 0; i < 16; i++) begin
            o_tready = rdy_pat[i % 4];
            tick(1);
        end
        o_tready = 1'b1;
        wait_bytes(4, "bp_count");
        tick(5);
        check("bp_no_dup", q_data.size(), 32'd4);
        check_bytes(8'h21, 4, 16'b1000);
        rst_a = 1'b1;

        // Small FIFO overflow
        sel = 1; rst_b = 1'b0; tick(1);
        push_bytes(8'h51, 6);
        check("ovf_level", {29'd0, lv_b}, 32'd4);
        check("ovf_count", {16'd0, oc_b}, 32'd2);
        clear_q();
        press();
        wait_bytes(4, "ovf_deliver");
        check_bytes(8'h51, 4, 16'b1000);
        check("ovf_page", {16'd0, pc_b}, 32'd1);
        check("ovf_end_level", {29'd0, lv_b}, 32'd0);
        rst_b = 1'b1;

        // Stream mode: 7 bytes, eof, pages of 3
        sel = 2; o_tready = 1'b0; rst_c = 1'b0; tick(1);
        push_bytes(8'h61, 7);
        i_eof = 1'b1; tick(1); i_eof = 1'b0;
        clear_q();
        o_tready = 1'b1;
        wait_bytes(7, "st_count");
        check_bytes(8'h61, 7, 16'b0110_0100);
        tick(5);
        check("st_state", {30'd0, st_c}, 32'd2);
        check("st_page", {16'd0, pc_c}, 32'd3);
        check("st_level", {27'd0, lv_c}, 32'd0);

        // Reset mid-stream discards the FIFO and overrides a same-cycle push
        rst_c = 1'b1; tick(1); rst_c = 1'b0;
        o_tready = 1'b0;
        push_bytes(8'h71, 5);
        o_tready = 1'b1; tick(2);
        rst_c = 1'b1; i_en = 1'b1; i_data = 8'h7F; tick(1);
        check("mid_rst_tvalid", {31'd0, tv_c}, 32'd0);
        check("mid_rst_level", {27'd0, lv_c}, 32'd0);
        check("mid_rst_state", {30'd0, st_c}, 32'd0);
        check("mid_rst_page", {16'd0, pc_c}, 32'd0);
        rst_c = 1'b0; i_en = 1'b0; tick(3);
        check("no_resume_tvalid", {31'd0, tv_c}, 32'd0);
        check("no_resume_level", {27'd0, lv_c}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
